junior_rr_arbiter: RTL
======================

Name: junior_rr_arbiter

Overview:
- Sequential round-robin arbiter that shares one resource between REQ_COUNT requesters.
- Winner selection is built on the lowest-set-bit screening primitive: a masked pass (bits above the last winner), then an unmasked fallback pass.
- Each grant is held until the grantee signals done, drops its request, or a hold-limit timeout fires.
- Sits between requesting masters and a shared datapath port (bus, ALU, memory port).

Parameters:
- REQ_COUNT, 8, number of requesters; must be ≥1.
- MAX_HOLD, 16, maximum grant length in cycles; 0 = unlimited.
- IDX_WIDTH, ($clog2(REQ_COUNT) > 0 ? $clog2(REQ_COUNT) : 1), width of grant_idx. Derived; not overridden.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, REQ_COUNT, request vector; bit i = requester i.
- en_mask, input, REQ_COUNT, per-requester enable; 0 excludes the bit from selection.
- done, input, 1, one-cycle release from the current grantee; ignored when not busy.
- grant, output, REQ_COUNT, registered one-hot grant, or all-zero.
- grant_idx, output, IDX_WIDTH, binary index of the set grant bit; 0 when grant=0.
- busy, output, 1, high while a grant is held (state BUSY).
- timeout, output, 1, one-cycle pulse in the cycle after a grant was ended by the hold limit.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values (asynchronous, while rst_n=0):
  - grant=0, grant_idx=0, busy=0, timeout=0.
  - State=IDLE, hold_cnt=0, pri_mask=all ones (bit 0 highest priority after reset).
  - Reset mid-BUSY drops the grant immediately, with no timeout pulse.
- Selection (combinational, used only in IDLE):
  - cand = req & en_mask; masked = cand & pri_mask.
  - If masked≠0, winner = lowest set bit of masked; otherwise winner = lowest set bit of cand.
  - cand=0 → no winner.
- State IDLE:
  - busy=0, grant=0.
  - If a winner exists at the edge: grant←one-hot winner, grant_idx←its index, hold_cnt←0, state←BUSY.
  - Grant latency: req sampled at edge k, grant visible after edge k (one cycle).
- State BUSY:
  - grant and grant_idx are held constant; busy=1.
  - req and en_mask changes of other bits are ignored. Clearing en_mask of the grantee does not revoke the grant.
  - Release conditions, evaluated each edge in priority order:
    1. done=1 → release, no timeout.
    2. req[grantee]=0 → release (abandon), no timeout.
    3. MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1 → release, timeout←1 for the next cycle.
    4. Otherwise hold_cnt←hold_cnt+1.
  - On release: grant←0, state←IDLE, pri_mask←bits strictly above the grantee. If the grantee is bit REQ_COUNT-1, pri_mask←0, which forces the fallback pass.
  - Release always passes through exactly one IDLE cycle; there is no back-to-back handoff. Minimum request-to-request grant spacing = 1 gap cycle.
- Grant length: a grant lasts exactly MAX_HOLD cycles on timeout, and exactly n cycles when done is sampled on the n-th BUSY edge.
- Counter and pulses:
  - hold_cnt width is sufficient for MAX_HOLD-1; with MAX_HOLD=0 it never wraps (saturates).
  - timeout is high for one cycle only; it is cleared on every other edge.
- Boundary cases:
  - REQ_COUNT=1 degenerates to a grant/release FSM; grant_idx stays 0.
  - Simultaneous done and timeout condition → done wins; timeout stays 0.
  - done in IDLE has no effect.
  - en_mask=0 or req=0 → stays IDLE indefinitely.
  - Requests arriving during BUSY wait; none are lost while held high.

Test Plan:
- REQ_COUNT=4, MAX_HOLD=4 for all scenarios below.
- Rotation: req=1111 held; done pulsed on the 2nd BUSY cycle of each grant → grants 0001, 0010, 0100, 1000, 0001, with grant_idx 0, 1, 2, 3, 0, each separated by one IDLE cycle.
- Skip and wrap: after grant 0010 released, req=1010 → next grant 1000. After release, req=1010 → 0010 (fallback pass, pri_mask=0).
- Timeout: req=0001 held, done never asserted → grant=0001 for exactly 4 cycles; timeout=1 in the following IDLE cycle; grant 0001 reissued the cycle after.
- Masking and abandon:
  - en_mask=1101, req=0010 → grant stays 0000, busy=0.
  - Then en_mask=1111 → grant 0010 one cycle later.
  - Drop req[1] in BUSY → grant 0000 next cycle, timeout=0.
- Collision and reset:
  - done=1 on the 4th BUSY cycle → release with timeout=0.
  - Asserting rst_n=0 mid-BUSY → grant, busy and timeout go 0 asynchronously. After release, req=1111 → first grant 0001.

Source files
------------

// File: rtl/junior_rr_arbiter.sv
// junior_rr_lsb: isolates the lowest set bit of a vector and encodes its position.
// Latency: purely combinational, zero cycles.
// Backpressure: none; this block only screens a vector and does not hold any state.
module junior_rr_lsb #(
   parameter int WIDTH     = 8,
   parameter int IDX_WIDTH = 3
) (
   input  logic [WIDTH-1:0]     vec,
   output logic [WIDTH-1:0]     onehot,
   output logic [IDX_WIDTH-1:0] idx,
   output logic                 any
);

   // Two's-complement trick keeps only the lowest set bit; the downward scan leaves the lowest index in idx.
   always_comb begin
      onehot = vec & (~vec + WIDTH'(1));
      idx    = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IDX_WIDTH'(i);
         end
      end
      any = |vec;
   end

endmodule

// junior_rr_arbiter: round-robin grant of one shared port among REQ_COUNT requesters.
// Latency: a request sampled at an edge is granted after that edge; every release inserts one idle cycle.
// Backpressure: a held grant blocks all other requesters, which wait with req high until release.
module junior_rr_arbiter #(
   parameter int REQ_COUNT = 8,
   parameter int MAX_HOLD  = 16,
   parameter int IDX_WIDTH = ($clog2(REQ_COUNT) > 0 ? $clog2(REQ_COUNT) : 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [REQ_COUNT-1:0] req,
   input  logic [REQ_COUNT-1:0] en_mask,
   input  logic                 done,
   output logic [REQ_COUNT-1:0] grant,
   output logic [IDX_WIDTH-1:0] grant_idx,
   output logic                 busy,
   output logic                 timeout
);

   // The counter only needs to reach MAX_HOLD-1; an unlimited hold keeps a 1-bit saturating counter.
   localparam int                HOLD_W       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam int                HOLD_LAST_I  = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
   localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(HOLD_LAST_I);
   localparam bit                HOLD_LIMITED = (MAX_HOLD != 0);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [REQ_COUNT-1:0]   grant_q;
   logic [REQ_COUNT-1:0]   grant_d;
   logic [IDX_WIDTH-1:0]   grant_idx_q;
   logic [IDX_WIDTH-1:0]   grant_idx_d;
   logic [HOLD_W-1:0]      hold_cnt_q;
   logic [HOLD_W-1:0]      hold_cnt_d;
   logic [REQ_COUNT-1:0]   pri_mask_q;
   logic [REQ_COUNT-1:0]   pri_mask_d;
   logic                   timeout_q;
   logic                   timeout_d;

   logic [REQ_COUNT-1:0]   cand;
   logic [REQ_COUNT-1:0]   masked;
   logic [REQ_COUNT-1:0]   masked_oh;
   logic [IDX_WIDTH-1:0]   masked_idx;
   logic                   masked_any;
   logic [REQ_COUNT-1:0]   cand_oh;
   logic [IDX_WIDTH-1:0]   cand_idx;
   logic                   cand_any;
   logic [REQ_COUNT-1:0]   win_oh;
   logic [IDX_WIDTH-1:0]   win_idx;
   logic                   grantee_req;
   logic [REQ_COUNT-1:0]   above_grantee;
   logic                   release_c;

   // Eligible requesters, and the subset sitting above the last winner.
   always_comb begin
      cand   = req & en_mask;
      masked = cand & pri_mask_q;
   end

   // Masked pass: lowest eligible requester above the last winner.
   junior_rr_lsb #(
      .WIDTH     (REQ_COUNT),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_masked_pick (
      .vec    (masked),
      .onehot (masked_oh),
      .idx    (masked_idx),
      .any    (masked_any)
   );

   // Fallback pass: lowest eligible requester overall, used when the masked pass is empty.
   junior_rr_lsb #(
      .WIDTH     (REQ_COUNT),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_cand_pick (
      .vec    (cand),
      .onehot (cand_oh),
      .idx    (cand_idx),
      .any    (cand_any)
   );

   // Winner choice plus grantee-derived helpers for the release path.
   always_comb begin
      win_oh        = masked_any ? masked_oh  : cand_oh;
      win_idx       = masked_any ? masked_idx : cand_idx;
      grantee_req   = |(req & grant_q);
      // Bits strictly above the one-hot grantee; the top requester yields all zeros.
      above_grantee = ~(grant_q | (grant_q - REQ_COUNT'(1)));
   end

   // Next-state logic: grant from IDLE, then release on done, abandon or hold limit, in that order.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      grant_idx_d = grant_idx_q;
      hold_cnt_d  = hold_cnt_q;
      pri_mask_d  = pri_mask_q;
      timeout_d   = 1'b0;
      release_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cand_any) begin
               state_d     = BUSY;
               grant_d     = win_oh;
               grant_idx_d = win_idx;
               hold_cnt_d  = '0;
            end
         end
         BUSY: begin
            if (done) begin
               release_c = 1'b1;
            end else if (!grantee_req) begin
               release_c = 1'b1;
            end else if (HOLD_LIMITED && (hold_cnt_q == HOLD_LAST)) begin
               release_c = 1'b1;
               timeout_d = 1'b1;
            end else if (hold_cnt_q != '1) begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
            if (release_c) begin
               state_d     = IDLE;
               grant_d     = '0;
               grant_idx_d = '0;
               pri_mask_d  = above_grantee;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset drops any grant at once and restores bit 0 as top priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         grant_idx_q <= '0;
         hold_cnt_q  <= '0;
         pri_mask_q  <= '1;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         grant_idx_q <= grant_idx_d;
         hold_cnt_q  <= hold_cnt_d;
         pri_mask_q  <= pri_mask_d;
         timeout_q   <= timeout_d;
      end
   end

   assign grant     = grant_q;
   assign grant_idx = grant_idx_q;
   assign busy      = (state_q == BUSY);
   assign timeout   = timeout_q;

endmodule
